// File: rtl/pe_online_accum.sv
// pe_online_accum
// Holds one Q vector and streams a runtime-selected number of K/V rows
// against it. For each row it forms the dot-product score, then updates a
// running max m, a running denominator l and an un-normalised output O*
// using a base-2 online softmax. All rescaling is done with shifts. At the
// end of the sequence it presents O*, l and m to the downstream divider path.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset; aborts any sequence in flight
//   q_vld_in     Q vector + seq_len valid
//   q_rdy_out    ready for a new Q (only in IDLE)
//   q_vector     DIM signed lanes, lane i at [i*DATA_W +: DATA_W]
//   seq_len      number of K/V rows paired with this Q
//   kv_vld_in    K and V valid (joint)
//   kv_rdy_out   ready for a K/V row (only while streaming)
//   k_vector     DIM signed lanes
//   v_vector     DIM signed lanes
//   o_vld_out    result valid; held until o_rdy_in
//   o_rdy_in     downstream ready
//   o_vector     DIM signed O* lanes, lane i at [i*ACC_W +: ACC_W]
//   l_out        running denominator (unit weight W1 = 1 << FRAC_W)
//   m_out        final max score, SW bits signed
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a Q vector; q_rdy_out high
// STREAM | accepting K/V rows, one per cycle, until rem reaches 0
// DRAIN  | last row is still in the score / update pipeline
// OUT    | result presented; waits for o_rdy_in
module pe_online_accum #(
   parameter int DIM         = 64,
   parameter int DATA_W      = 8,
   parameter int SCORE_SHIFT = 0,
   parameter int FRAC_W      = 16,
   parameter int ACC_W       = 40,
   parameter int LEN_W       = 10,
   localparam int SW         = 2*DATA_W + $clog2(DIM) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    q_vld_in,
   output logic                    q_rdy_out,
   input  logic [DIM*DATA_W-1:0]   q_vector,
   input  logic [LEN_W-1:0]        seq_len,
   input  logic                    kv_vld_in,
   output logic                    kv_rdy_out,
   input  logic [DIM*DATA_W-1:0]   k_vector,
   input  logic [DIM*DATA_W-1:0]   v_vector,
   output logic                    o_vld_out,
   input  logic                    o_rdy_in,
   output logic [DIM*ACC_W-1:0]    o_vector,
   output logic [ACC_W-1:0]        l_out,
   output logic [SW-1:0]           m_out
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUT} state_t;

   // One extra bit so the difference of two SW-bit scores never overflows.
   localparam int DW  = SW + 1;
   localparam int SHW = $clog2(ACC_W + 1);
   localparam int FSH = $clog2(FRAC_W + 2);
   localparam logic [ACC_W-1:0] W1 = ACC_W'(1) << FRAC_W;

   state_t                   state;
   logic [LEN_W-1:0]         rem;
   logic [1:0]               drain_tmr;

   logic [DIM*DATA_W-1:0]    q_reg;

   logic                     s1_vld;
   logic signed [SW-1:0]     s1_score;
   logic [DIM*DATA_W-1:0]    s1_v;

   logic signed [ACC_W-1:0]  o_acc [DIM];
   logic [ACC_W-1:0]         l_acc;
   logic signed [SW-1:0]     m_acc;
   logic                     first;

   logic                     q_hs;
   logic                     kv_hs;

   assign q_hs  = q_vld_in && q_rdy_out;
   assign kv_hs = kv_vld_in && kv_rdy_out;

   // ---------------------------------------------------------------
   // Stage 1: full-precision dot product of latched Q with incoming K
   // ---------------------------------------------------------------
   logic signed [SW-1:0] dot_sum;
   logic signed [SW-1:0] score;

   always_comb begin
      dot_sum = '0;
      for (int i = 0; i < DIM; i++) begin
         dot_sum = dot_sum + SW'($signed(q_reg[i*DATA_W +: DATA_W]))
                           * SW'($signed(k_vector[i*DATA_W +: DATA_W]));
      end
   end

   assign score = dot_sum >>> SCORE_SHIFT;

   // ---------------------------------------------------------------
   // Stage 2: online-softmax update, combinational next values
   // ---------------------------------------------------------------
   logic                     s_gt;
   logic [DW-1:0]            diff;
   logic [SHW-1:0]           sh_acc;
   logic [FSH-1:0]           sh_w;
   logic                     w_zero;
   logic [ACC_W-1:0]         w_val;
   logic [ACC_W-1:0]         l_nxt;
   logic signed [SW-1:0]     m_nxt;
   logic signed [ACC_W-1:0]  v_ext [DIM];
   logic signed [ACC_W-1:0]  o_nxt [DIM];
   logic [DIM*ACC_W-1:0]     o_flat;

   always_comb begin
      s_gt = s1_score > m_acc;
      if (s_gt) begin
         diff = DW'(s1_score) - DW'(m_acc);
      end else begin
         diff = DW'(m_acc) - DW'(s1_score);
      end

      // Shifts of ACC_W or more collapse to the sign fill (0 or -1 for O*,
      // 0 for l); clamping keeps the shifter narrow.
      sh_acc = (diff >= DW'(ACC_W)) ? SHW'(ACC_W) : SHW'(diff);

      // A row more than FRAC_W below the max has a weight that underflows
      // the fraction and contributes nothing.
      w_zero = diff > DW'(FRAC_W);
      sh_w   = FSH'(FRAC_W) - FSH'(diff);
      w_val  = w_zero ? '0 : (ACC_W'(1) << sh_w);

      if (first) begin
         l_nxt = W1;
      end else if (s_gt) begin
         l_nxt = (l_acc >> sh_acc) + W1;
      end else begin
         l_nxt = l_acc + w_val;
      end

      m_nxt = (first || s_gt) ? s1_score : m_acc;

      for (int i = 0; i < DIM; i++) begin
         v_ext[i] = ACC_W'($signed(s1_v[i*DATA_W +: DATA_W]));
         if (first) begin
            o_nxt[i] = v_ext[i] <<< FRAC_W;
         end else if (s_gt) begin
            o_nxt[i] = (o_acc[i] >>> sh_acc) + (v_ext[i] <<< FRAC_W);
         end else begin
            // w is a power of two, so v*w is v shifted by (FRAC_W - d).
            o_nxt[i] = o_acc[i] + (w_zero ? '0 : (v_ext[i] <<< sh_w));
         end
      end
   end

   always_comb begin
      o_flat = '0;
      for (int i = 0; i < DIM; i++) begin
         o_flat[i*ACC_W +: ACC_W] = o_acc[i];
      end
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg    <= '0;
         s1_vld   <= 1'b0;
         s1_score <= '0;
         s1_v     <= '0;
         l_acc    <= '0;
         m_acc    <= '0;
         first    <= 1'b0;
         for (int i = 0; i < DIM; i++) begin
            o_acc[i] <= '0;
         end
      end else begin
         s1_vld <= kv_hs;
         if (kv_hs) begin
            s1_score <= score;
            s1_v     <= v_vector;
         end

         // A Q handshake and a stage-2 update never coincide: stage 1 only
         // fills while streaming.
         if (q_hs) begin
            q_reg <= q_vector;
            l_acc <= '0;
            m_acc <= '0;
            first <= 1'b1;
            for (int i = 0; i < DIM; i++) begin
               o_acc[i] <= '0;
            end
         end else if (s1_vld) begin
            l_acc <= l_nxt;
            m_acc <= m_nxt;
            first <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
               o_acc[i] <= o_nxt[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Sequencing FSM with registered handshake and result outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rem        <= '0;
         drain_tmr  <= '0;
         q_rdy_out  <= 1'b0;
         kv_rdy_out <= 1'b0;
         o_vld_out  <= 1'b0;
         o_vector   <= '0;
         l_out      <= '0;
         m_out      <= '0;
      end else begin
         case (state)
            IDLE: begin
               q_rdy_out <= 1'b1;
               if (q_hs) begin
                  q_rdy_out <= 1'b0;
                  if (seq_len == '0) begin
                     state     <= OUT;
                     o_vld_out <= 1'b1;
                     o_vector  <= '0;
                     l_out     <= '0;
                     m_out     <= '0;
                  end else begin
                     state      <= STREAM;
                     rem        <= seq_len;
                     kv_rdy_out <= 1'b1;
                  end
               end
            end

            STREAM: begin
               if (kv_hs) begin
                  rem <= rem - 1'b1;
                  if (rem == LEN_W'(1)) begin
                     kv_rdy_out <= 1'b0;
                     state      <= DRAIN;
                     // One cycle for stage 1 -> stage 2, then capture.
                     drain_tmr  <= 2'd1;
                  end
               end
            end

            DRAIN: begin
               if (drain_tmr == '0) begin
                  state     <= OUT;
                  o_vld_out <= 1'b1;
                  o_vector  <= o_flat;
                  l_out     <= l_acc;
                  m_out     <= m_acc;
               end else begin
                  drain_tmr <= drain_tmr - 1'b1;
               end
            end

            OUT: begin
               if (o_rdy_in) begin
                  o_vld_out <= 1'b0;
                  q_rdy_out <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
